// File: rtl/uart_pkg.sv
// uart_pkg: constants and helpers shared by the UART transmitter and receiver.
// SOF/EOF delimiters bracket every host-bound frame; the receiver parses the same values.
package uart_pkg;

    localparam logic [7:0] SOF_BYTE = 8'h00;
    localparam logic [7:0] EOF_BYTE = 8'hFF;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    // Clocks per bit cell, truncating division (434 for 50 MHz / 115200).
    function automatic int clks_per_bit(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous FIFO with occupancy count.
// DEPTH must be a power of two so the pointers wrap naturally.
module uart_tx_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 16
)(
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Full/empty come from the pre-edge count, so a push into a full FIFO is refused
    assign full      = (count_r == FULL_COUNT);
    assign empty     = (count_r == {CW{1'b0}});
    assign push_ok_s = push & ~full;
    assign pop_ok_s  = pop & ~empty;
    assign rd_data   = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Storage array; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; push+pop together leaves the count alone
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/uart_frame_tx.sv
// uart_frame_tx: 8N1 UART transmitter (LSB first) fed from an input FIFO.
// Define UART_TX_FRAMING_EN to wrap each frame in SOF (0x00) / EOF (0xFF) bytes;
// without it the block is a raw byte transmitter and tx_last is ignored.
module uart_frame_tx #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 16,
    parameter int STOP_BITS  = 1
)(
    input  logic                          CLOCK_50,
    input  logic                          reset_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_last,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          Tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          err_reserved
);
    import uart_pkg::*;

    localparam int CPB       = clks_per_bit(CLK_FREQ, BAUD);
    localparam int STOP_CLKS = CPB * STOP_BITS;
    localparam int BCW       = $clog2(STOP_CLKS + 1);
    localparam int CW        = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BCW-1:0] BIT_END  = BCW'(CPB - 1);
    localparam logic [BCW-1:0] STOP_END = BCW'(STOP_CLKS - 1);
    localparam logic [BCW-1:0] BAUD_ONE = BCW'(1);

    tx_state_t       state_r;
    tx_state_t       state_next_s;
    logic [BCW-1:0]  baud_cnt_r;
    logic [2:0]      bit_idx_r;
    logic [7:0]      shift_r;
    logic            tx_r;
    logic            tx_next_s;
    logic            baud_end_s;
    logic            stop_end_s;
    logic            load_s;
    logic            pop_s;
    logic            src_avail_s;
    logic            src_pop_s;
    logic [7:0]      src_byte_s;
    logic            accept_s;
    logic            push_s;
    logic [8:0]      push_data_s;
    logic [8:0]      fifo_rd_s;
    logic            fifo_full_s;
    logic            fifo_empty_s;
    logic [CW-1:0]   count_s;

    uart_tx_fifo #(
        .WIDTH (9),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (CLOCK_50),
        .reset_n (reset_n),
        .push    (push_s),
        .wr_data (push_data_s),
        .pop     (pop_s),
        .rd_data (fifo_rd_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s),
        .count   (count_s)
    );

    assign accept_s   = tx_valid & ~fifo_full_s;
    assign tx_ready   = ~fifo_full_s;
    assign fifo_count = count_s;
    assign busy       = (state_r != TX_IDLE) | (count_s != {CW{1'b0}});
    assign Tx         = tx_r;
    assign baud_end_s = (baud_cnt_r == BIT_END);
    assign stop_end_s = (baud_cnt_r == STOP_END);
    assign load_s     = (state_next_s == TX_START) &&
                        ((state_r == TX_IDLE) || (state_r == TX_STOP));
    assign pop_s      = load_s & src_pop_s;

`ifdef UART_TX_FRAMING_EN
    logic sof_pending_r;
    logic eof_pending_r;
    logic err_r;
    logic reserved_s;

    // Next line byte: a pending EOF wins, then SOF ahead of queued payload, then payload
    always_comb begin
        src_avail_s = 1'b0;
        src_pop_s   = 1'b0;
        src_byte_s  = fifo_rd_s[7:0];
        if (eof_pending_r) begin
            src_avail_s = 1'b1;
            src_byte_s  = EOF_BYTE;
        end else if (!fifo_empty_s) begin
            src_avail_s = 1'b1;
            if (sof_pending_r) begin
                src_byte_s = SOF_BYTE;
            end else begin
                src_pop_s  = 1'b1;
                src_byte_s = fifo_rd_s[7:0];
            end
        end else begin
            src_avail_s = 1'b0;
        end
    end

    // Delimiter values are swallowed; a delimiter flagged last queues a bare EOF marker {1,FF}
    always_comb begin
        reserved_s  = (tx_data == SOF_BYTE) || (tx_data == EOF_BYTE);
        push_s      = accept_s;
        push_data_s = {tx_last, tx_data};
        if (reserved_s) begin
            push_s      = accept_s & tx_last;
            push_data_s = {1'b1, EOF_BYTE};
        end else begin
            push_s      = accept_s;
            push_data_s = {tx_last, tx_data};
        end
    end

    // Frame bookkeeping, advanced whenever a byte is loaded into the shifter
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            sof_pending_r <= 1'b1;
            eof_pending_r <= 1'b0;
        end else if (load_s) begin
            if (eof_pending_r) begin
                eof_pending_r <= 1'b0;
                sof_pending_r <= 1'b1;
            end else if (sof_pending_r) begin
                sof_pending_r <= 1'b0;
            end else if (fifo_rd_s[8]) begin
                if (fifo_rd_s[7:0] == EOF_BYTE) begin
                    sof_pending_r <= 1'b1;
                end else begin
                    eof_pending_r <= 1'b1;
                end
            end
        end
    end

    // One-cycle flag for a delimiter value offered as payload
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            err_r <= 1'b0;
        end else begin
            err_r <= accept_s & reserved_s;
        end
    end

    assign err_reserved = err_r;
`else
    logic unused_last_s;

    // Raw mode: every accepted byte is queued and sent unchanged
    always_comb begin
        src_avail_s = ~fifo_empty_s;
        src_pop_s   = 1'b1;
        src_byte_s  = fifo_rd_s[7:0];
        push_s      = accept_s;
        push_data_s = {tx_last, tx_data};
    end

    assign unused_last_s = fifo_rd_s[8];
    assign err_reserved  = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= TX_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // FSM next state; STOP chains straight into START when another byte is ready
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            TX_IDLE: begin
                if (src_avail_s) state_next_s = TX_START;
                else             state_next_s = TX_IDLE;
            end
            TX_START: begin
                if (baud_end_s) state_next_s = TX_DATA;
                else            state_next_s = TX_START;
            end
            TX_DATA: begin
                if (baud_end_s && (bit_idx_r == 3'd7)) state_next_s = TX_STOP;
                else                                   state_next_s = TX_DATA;
            end
            TX_STOP: begin
                if (stop_end_s && src_avail_s)  state_next_s = TX_START;
                else if (stop_end_s)            state_next_s = TX_IDLE;
                else                            state_next_s = TX_STOP;
            end
            default: state_next_s = TX_IDLE;
        endcase
    end

    // FSM output: line level implied by the current state, registered below
    always_comb begin
        tx_next_s = 1'b1;
        case (state_r)
            TX_START: tx_next_s = 1'b0;
            TX_DATA:  tx_next_s = shift_r[bit_idx_r];
            TX_STOP:  tx_next_s = 1'b1;
            TX_IDLE:  tx_next_s = 1'b1;
            default:  tx_next_s = 1'b1;
        endcase
    end

    // Registered line driver; reset forces idle-high at once
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            tx_r <= 1'b1;
        end else begin
            tx_r <= tx_next_s;
        end
    end

    // Baud/bit counters and shift register; the baud counter restarts on every state entry
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            baud_cnt_r <= {BCW{1'b0}};
            bit_idx_r  <= 3'd0;
            shift_r    <= 8'h00;
        end else begin
            if (load_s) begin
                shift_r <= src_byte_s;
            end
            case (state_r)
                TX_START: begin
                    baud_cnt_r <= baud_end_s ? {BCW{1'b0}} : baud_cnt_r + BAUD_ONE;
                    bit_idx_r  <= 3'd0;
                end
                TX_DATA: begin
                    if (baud_end_s) begin
                        baud_cnt_r <= {BCW{1'b0}};
                        bit_idx_r  <= bit_idx_r + 3'd1;
                    end else begin
                        baud_cnt_r <= baud_cnt_r + BAUD_ONE;
                    end
                end
                TX_STOP: begin
                    baud_cnt_r <= stop_end_s ? {BCW{1'b0}} : baud_cnt_r + BAUD_ONE;
                    bit_idx_r  <= 3'd0;
                end
                default: begin
                    baud_cnt_r <= {BCW{1'b0}};
                    bit_idx_r  <= 3'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_frame_tx.sv
// tb_uart_frame_tx: randomized and directed bench for uart_frame_tx with a
// cycle-level behavioural model and an independent line decoder.
// Works in both builds (UART_TX_FRAMING_EN defined or not).
module tb_uart_frame_tx;
    import uart_pkg::*;

    localparam int CLK_FREQ  = 50000000;
    localparam int BAUD      = 10000000;
    localparam int DEPTH     = 16;
    localparam int STOP_BITS = 1;
    localparam int N         = CLK_FREQ / BAUD;
    localparam int CW        = $clog2(DEPTH) + 1;
    localparam int CHAR_CLKS = N * (9 + STOP_BITS);

    logic          CLOCK_50 = 1'b0;
    logic          reset_n  = 1'b0;
    logic [7:0]    tx_data  = 8'h00;
    logic          tx_last  = 1'b0;
    logic          tx_valid = 1'b0;
    logic          tx_ready;
    logic          Tx;
    logic          busy;
    logic [CW-1:0] fifo_count;
    logic          err_reserved;

    int checks = 0;
    int passed = 0;
    int cyc    = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    uart_frame_tx #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD       (BAUD),
        .FIFO_DEPTH (DEPTH),
        .STOP_BITS  (STOP_BITS)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .reset_n      (reset_n),
        .tx_data      (tx_data),
        .tx_last      (tx_last),
        .tx_valid     (tx_valid),
        .tx_ready     (tx_ready),
        .Tx           (Tx),
        .busy         (busy),
        .fifo_count   (fifo_count),
        .err_reserved (err_reserved)
    );

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    always @(posedge CLOCK_50) cyc++;

    // ---------------- behavioural model ----------------
    // Queue entry {marker, last, data}; a marker carries no payload and only closes a frame.
    logic [9:0] m_q[$];
    logic [7:0] m_line_q[$];
    bit         m_active = 1'b0;
    int         m_t      = 0;
    logic [7:0] m_byte   = 8'h00;
    bit         m_sof    = 1'b1;
    bit         m_eof    = 1'b0;
    bit         m_tx     = 1'b1;
    bit         m_err    = 1'b0;

    // Line level at position idx of a character: start 0, data LSB first, then stop 1s.
    function automatic logic frame_bit(input logic [7:0] b, input int idx);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        return 1'b1;
    endfunction

    // Choose the next byte for the line from the model state; returns 0 if none.
    function automatic bit take_source(output logic [7:0] b);
        logic [9:0] e;
        b = 8'h00;
`ifdef UART_TX_FRAMING_EN
        if (m_eof) begin
            b = 8'hFF; m_eof = 1'b0; m_sof = 1'b1; return 1'b1;
        end
        if (m_q.size() == 0) return 1'b0;
        if (m_sof) begin
            b = 8'h00; m_sof = 1'b0; return 1'b1;
        end
        e = m_q.pop_front();
        if (e[9]) begin
            b = 8'hFF; m_sof = 1'b1;
        end else begin
            b = e[7:0];
            if (e[8]) m_eof = 1'b1;
        end
        return 1'b1;
`else
        if (m_q.size() == 0) return 1'b0;
        e = m_q.pop_front();
        b = e[7:0];
        return 1'b1;
`endif
    endfunction

    always @(posedge CLOCK_50 or negedge reset_n) begin
        bit         acc;
        bit         rsv;
        logic [7:0] nb;
        if (!reset_n) begin
            m_q.delete();
            m_active = 1'b0; m_t = 0; m_sof = 1'b1; m_eof = 1'b0;
            m_tx = 1'b1; m_err = 1'b0;
        end else begin
            m_tx = m_active ? frame_bit(m_byte, m_t / N) : 1'b1;
            acc  = tx_valid && (m_q.size() != DEPTH);
            if (m_active && (m_t == CHAR_CLKS - 1)) begin
                m_line_q.push_back(m_byte);
                m_active = 1'b0;
            end else if (m_active) begin
                m_t++;
            end
            if (!m_active) begin
                if (take_source(nb)) begin
                    m_active = 1'b1; m_t = 0; m_byte = nb;
                end
            end
`ifdef UART_TX_FRAMING_EN
            rsv   = (tx_data == 8'h00) || (tx_data == 8'hFF);
            m_err = acc && rsv;
            if (acc && !rsv) m_q.push_back({1'b0, tx_last, tx_data});
            else if (acc && tx_last) m_q.push_back({1'b1, 1'b1, 8'hFF});
`else
            rsv   = 1'b0;
            m_err = rsv;
            if (acc) m_q.push_back({2'b00, tx_data});
`endif
        end
    end

    // Every-cycle comparison of all outputs against the model
    always @(negedge CLOCK_50) begin
        check("Tx", Tx, m_tx);
        check("tx_ready", tx_ready, m_q.size() != DEPTH);
        check("busy", busy, m_active || (m_q.size() != 0));
        check("fifo_count", fifo_count, m_q.size());
        check("err_reserved", err_reserved, m_err);
    end

    // ---------------- independent line decoder ----------------
    logic [7:0] rx_q[$];
    bit         rx_on = 1'b0;
    int         rx_cnt = 0;
    logic [7:0] rx_sh = 8'h00;
    int         rx_base = 0;
    int         err_seen = 0;
    int         max_cnt = 0;

    always @(negedge CLOCK_50) begin
        int b;
        if (!reset_n) begin
            rx_on = 1'b0;
        end else if (!rx_on) begin
            if (Tx == 1'b0) begin rx_on = 1'b1; rx_cnt = 0; end
        end else begin
            rx_cnt++;
            if (rx_cnt % N == N / 2) begin
                b = rx_cnt / N;
                if (b == 0) check("start_bit", Tx, 0);
                else if (b <= 8) rx_sh[b-1] = Tx;
                else begin
                    check("stop_bit", Tx, 1);
                    rx_q.push_back(rx_sh);
                    rx_on = 1'b0;
                end
            end
        end
        if (reset_n && err_reserved) err_seen++;
        if (int'(fifo_count) > max_cnt) max_cnt = int'(fifo_count);
    end

    // ---------------- stimulus helpers ----------------
    // Called just after a falling edge; returns just after the falling edge following acceptance.
    task automatic send(input logic [7:0] d, input logic l);
        int g = 0;
        tx_data = d; tx_last = l; tx_valid = 1'b1;
        while (!tx_ready && g < 2000) begin @(negedge CLOCK_50); g++; end
        check("send_wait", g < 2000, 1);
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        tx_valid = 1'b0;
    endtask

    task automatic drain();
        int g = 0;
        while ((busy || m_active || m_q.size() != 0) && g < 5000) begin
            @(negedge CLOCK_50); g++;
        end
        check("drain_wait", g < 5000, 1);
        repeat (2 * N) @(negedge CLOCK_50);
    endtask

    task automatic expect_line(input string name, input logic [7:0] exp[$]);
        check({name, "_len"}, rx_q.size() - rx_base, exp.size());
        for (int i = 0; i < exp.size(); i++) begin
            if (rx_base + i < rx_q.size()) check(name, rx_q[rx_base+i], exp[i]);
            else check(name, -1, exp[i]);
        end
        rx_base = rx_q.size();
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [7:0] e[$];
        logic [9:0] pat;
        logic [7:0] d;
        logic       l;
        int         g;
        int         base;

        check("cpb_default", clks_per_bit(50000000, 115200), 434);
        check("cpb_bench", clks_per_bit(CLK_FREQ, BAUD), 5);

        // Reset values
        repeat (3) @(negedge CLOCK_50);
        check("rst_Tx", Tx, 1);
        check("rst_tx_ready", tx_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_err", err_reserved, 0);
        reset_n = 1'b1;
        repeat (3) @(negedge CLOCK_50);

        // Single byte 0x55: latency to start bit and bit pattern
        tx_data = 8'h55; tx_last = 1'b1; tx_valid = 1'b1;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50); tx_valid = 1'b0;
        check("lat_k", Tx, 1);
        @(negedge CLOCK_50); check("lat_k1", Tx, 1);
        @(negedge CLOCK_50); check("lat_k2", Tx, 0);
`ifdef UART_TX_FRAMING_EN
        pat = 10'h200;
`else
        pat = 10'h2AA;
`endif
        repeat (2) @(negedge CLOCK_50);
        check("bit0", Tx, pat[0]);
        for (int i = 1; i < 10; i++) begin
            repeat (N) @(negedge CLOCK_50);
            check("bit_pattern", Tx, pat[i]);
        end
        check("busy_mid", busy, 1);
        drain();
        check("busy_after", busy, 0);
`ifdef UART_TX_FRAMING_EN
        e = {8'h00, 8'h55, 8'hFF};
`else
        e = {8'h55};
`endif
        expect_line("single", e);

        // Back-to-back bytes: contiguous characters
        send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b1);
        drain();
`ifdef UART_TX_FRAMING_EN
        e = {8'h00, 8'h01, 8'h02, 8'h03, 8'hFF};
`else
        e = {8'h01, 8'h02, 8'h03};
`endif
        expect_line("b2b", e);

        // Fill the FIFO past its depth
        e.delete();
`ifdef UART_TX_FRAMING_EN
        e.push_back(8'h00);
`endif
        max_cnt = 0;
        for (int i = 0; i < 18; i++) begin
            d = 8'($urandom_range(1, 254));
            e.push_back(d);
            send(d, i == 17);
        end
`ifdef UART_TX_FRAMING_EN
        e.push_back(8'hFF);
`endif
        check("max_fifo_count", max_cnt, DEPTH);
        drain();
        expect_line("fill", e);

        // Reset during data bit 3
        send(8'hA5, 1'b0); send(8'h3C, 1'b0); send(8'h77, 1'b1);
        g = 0;
        while (!(m_active && (m_t / N) == 4) && g < 2000) begin @(negedge CLOCK_50); g++; end
        check("bit3_wait", g < 2000, 1);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_Tx", Tx, 1);
        check("midrst_count", fifo_count, 0);
        check("midrst_busy", busy, 0);
        repeat (2) @(negedge CLOCK_50);
        reset_n = 1'b1;
        base = rx_q.size();
        repeat (150) @(negedge CLOCK_50);
        check("midrst_no_chars", rx_q.size(), base);
        rx_base = rx_q.size();

        // Two frames
        send(8'h41, 1'b0); send(8'h42, 1'b1); send(8'h43, 1'b1);
        drain();
`ifdef UART_TX_FRAMING_EN
        e = {8'h00, 8'h41, 8'h42, 8'hFF, 8'h00, 8'h43, 8'hFF};
`else
        e = {8'h41, 8'h42, 8'h43};
`endif
        expect_line("frames", e);

        // Reserved payload value
        base = err_seen;
        send(8'hFF, 1'b0); send(8'h10, 1'b1);
        drain();
`ifdef UART_TX_FRAMING_EN
        check("err_pulses", err_seen - base, 1);
        e = {8'h00, 8'h10, 8'hFF};
`else
        check("err_pulses", err_seen - base, 0);
        e = {8'hFF, 8'h10};
`endif
        expect_line("reserved", e);

        // Randomized traffic, model checked every cycle
        for (int i = 0; i < 40; i++) begin
            d = 8'($urandom_range(0, 255));
            if ($urandom_range(0, 5) == 0) d = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
            l = ($urandom_range(0, 3) == 0);
            send(d, l);
            repeat ($urandom_range(0, 25)) @(negedge CLOCK_50);
        end
        send(8'h5A, 1'b1);
        drain();

        // Whole-run line content against the model's emitted characters
        check("line_total", rx_q.size(), m_line_q.size());
        for (int i = 0; i < rx_q.size() && i < m_line_q.size(); i++)
            check("line_byte", rx_q[i], m_line_q[i]);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
